nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs a wide (4*NIBBLES-bit) addition by reusing a single 4-bit ripple-adder slice over successive clock cycles, least-significant nibble first.
- Owns operand shift registers, the inter-nibble carry register and a small FSM.
- Instantiates the team's 4-bit dataflow ripple adder as its only arithmetic resource.
- Uses valid/ready handshakes on both the command side and the result side.
- Trades latency for area in wide-add datapaths.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 1..16, other values unsupported.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start_valid  input  1  command request
start_ready  output  1  block can accept a command
a_in  input  W  operand A, sampled on accept
b_in  input  W  operand B, sampled on accept
cin  input  1  carry-in, sampled on accept
sum_out  output  W  result sum, stable while done_valid=1
cout  output  1  final carry-out, stable while done_valid=1
done_valid  output  1  result available
done_ready  input  1  consumer accepts result
busy  output  1  high in RUN or DONE

Behaviour:
- Clocking and reset: single clock clk. Reset is synchronous and active-high on port reset.
- Reset values: state=IDLE, start_ready=1 (combinational from IDLE), done_valid=0, busy=0, sum_out=0, cout=0, all internal registers 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - Accept happens when start_valid=1 at a rising edge.
  - On accept: a_sh<=a_in, b_sh<=b_in, carry<=cin, cnt<=0, sum register<=0, go to RUN.
- RUN:
  - start_ready=0.
  - Adder slice inputs: a=a_sh[3:0], b=b_sh[3:0], carry_in=carry.
  - Each edge:
    - slice sum is shifted into the top nibble of the sum register, and the sum register shifts right 4;
    - carry<=slice carry_out;
    - a_sh and b_sh shift right 4, zero-filled;
    - cnt<=cnt+1.
  - When cnt==NIBBLES-1 at an edge, that edge performs the final nibble and the state goes to DONE.
- DONE:
  - done_valid=1. sum_out = sum register. cout = carry.
  - Outputs hold unchanged for as long as done_ready=0.
  - When done_valid and done_ready are both 1 at an edge, go to IDLE.
- Latency: with accept at edge k, done_valid is first high in the cycle after edge k+NIBBLES (NIBBLES RUN cycles).
  - Minimum issue interval is NIBBLES+2 cycles. There is no overlap between a result and the next command.
- Input stability: a_in, b_in and cin are ignored outside the accept edge. Changes during RUN or DONE have no effect.
- start_valid while not in IDLE: ignored, not queued. The requester must hold start_valid until start_ready.
- Arithmetic: result equals (A + B + cin) mod 2^W, with cout = bit W of the full sum. Carry propagates between nibbles only through the carry register.
- NIBBLES=1: exactly one RUN cycle. Result equals a direct 4-bit add.
- cnt width: clog2(NIBBLES)+1 bits. cnt never wraps within an operation.
- Reset mid-operation: reset in RUN or DONE aborts at that edge.
  - No done_valid pulse is produced and the partial sum is discarded.
  - The next cycle is IDLE with start_ready=1.
- Simultaneous reset and start_valid: reset wins and the command is dropped.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on accept.
  - If sub=1: b_sh<=~b_in, and carry<=1 (cin is ignored), so the block computes A - B.
  - cout=1 means no borrow (A>=B unsigned).
- Not defined: no sub port; behaviour is add only, exactly as above.

Test Plan:
- NIBBLES=4, a_in=16'h1234, b_in=16'h4321, cin=0, done_ready=1 -> sum_out=16'h5555, cout=0, done_valid high exactly 4 cycles after the accept edge.
- a_in=16'hFFFF, b_in=16'h0001, cin=0 -> sum_out=16'h0000, cout=1 (carry ripples through all 4 nibbles). a_in=16'hFFFF, b_in=16'hFFFF, cin=1 -> sum_out=16'hFFFF, cout=1.
- Result backpressure: hold done_ready=0 for 5 cycles after done_valid, pulse start_valid with new operands -> sum_out/cout unchanged, start_ready=0, command not taken. After the done handshake, start_ready=1.
- Assert reset 2 cycles into RUN -> done_valid stays 0, the next cycle shows start_ready=1 and busy=0. A following add of 3+6 yields 16'h0009, cout=0.
- NIBBLES=1 build: a_in=4'b0001, b_in=4'b0001, cin=1 -> sum_out=4'd3, cout=0, done_valid 1 cycle after accept.
- SERIAL_ADDER_SUB_EN defined: sub=1, a_in=16'h0005, b_in=16'h0007 -> sum_out=16'hFFFE, cout=0. sub=1, a_in=16'h0009, b_in=16'h0003 -> sum_out=16'h0006, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: wide add via one reused 4-bit ripple slice, LSB nibble first; SERIAL_ADDER_SUB_EN adds a subtract port
module nibble_ripple_add (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;
   assign c[0] = ci;
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[4];
endmodule

module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [4*NIBBLES-1:0] a_in,
   input  logic [4*NIBBLES-1:0] b_in,
   input  logic                 cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic                 sub,
`endif
   output logic [4*NIBBLES-1:0] sum_out,
   output logic                 cout,
   output logic                 done_valid,
   input  logic                 done_ready,
   output logic                 busy
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES) + 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t         state;
   logic [W-1:0]   a_sh, b_sh, sum_r, b_acc;
   logic           carry, c_acc, co;
   logic [CW-1:0]  cnt;
   logic [3:0]     s;
   nibble_ripple_add u_add (
      .a (a_sh[3:0]),
      .b (b_sh[3:0]),
      .ci(carry),
      .s (s),
      .co(co)
   );
`ifdef SERIAL_ADDER_SUB_EN
   assign b_acc = sub ? ~b_in : b_in;
   assign c_acc = sub | cin;
`else
   assign b_acc = b_in;
   assign c_acc = cin;
`endif
   assign start_ready = (state == IDLE);
   assign sum_out     = sum_r;
   assign cout        = carry;
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         sum_r      <= '0;
         carry      <= 1'b0;
         cnt        <= '0;
         done_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_valid) begin
               a_sh  <= a_in;
               b_sh  <= b_acc;
               carry <= c_acc;
               cnt   <= '0;
               sum_r <= '0;
               busy  <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               // new slice enters at the top so the first nibble ends at the bottom
               sum_r <= W'({s, sum_r} >> 4);
               carry <= co;
               a_sh  <= a_sh >> 4;
               b_sh  <= b_sh >> 4;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(NIBBLES - 1)) begin
                  state      <= DONE;
                  done_valid <= 1'b1;
               end
            end
            DONE: if (done_ready) begin
               state      <= IDLE;
               done_valid <= 1'b0;
               busy       <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: scoreboard bench with random and directed add/subtract commands
module tb_nibble_serial_adder_ctrl;
   localparam int NIBBLES = 4;
   localparam int W = 4 * NIBBLES;
   typedef struct {
      logic [W:0] r;
      int         acc;
   } exp_t;
   logic clk = 0, reset = 1, start_valid = 0, start_ready, cin = 0, cout, done_valid, done_ready = 0, busy;
   logic sub = 0;
   logic [W-1:0] a_in = '0, b_in = '0, sum_out;
   int checks = 0, errors = 0, cyc = 0, rdy_mode = 0;
   exp_t q[$];
   logic prev_dv = 0;
   nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
      .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .sum_out(sum_out), .cout(cout), .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
      logic [W:0] r;
      if (s) begin
         r[W-1:0] = a - b;
         r[W] = (a >= b);
      end else r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      return r;
   endfunction
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
      int n = 0;
      exp_t e;
      @(negedge clk);
      start_valid = 1; a_in = a; b_in = b; cin = c; sub = s;
      while (!start_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!start_ready) begin
         chk("accept_timeout", 0, 1);
      end else begin
         e.r = model(a, b, c, s);
         e.acc = cyc + 1;
         q.push_back(e);
      end
      @(posedge clk);
      #1 start_valid = 0;
      a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
   endtask
   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((!start_ready || q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("idle_timeout", 0, 1);
   endtask
   // Monitor: compares every presented result against the scoreboard and drives done_ready
   always @(negedge clk) begin
      if (!reset) begin
         if (done_valid) begin
            if (q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               if (!prev_dv) chk("latency", 68'(cyc - q[0].acc), 68'(NIBBLES));
               chk("result", {cout, sum_out}, q[0].r);
            end
         end
         done_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
         if (done_valid && done_ready && q.size() != 0) void'(q.pop_front());
         prev_dv = done_valid;
      end else prev_dv = 0;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_start_ready", start_ready, 1);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", sum_out, 0);
      chk("rst_cout", cout, 0);
      issue(W'(16'h1234), W'(16'h4321), 0, 0);
      issue(W'(16'hFFFF), W'(16'h0001), 0, 0);
      issue(W'(16'hFFFF), W'(16'hFFFF), 1, 0);
      issue(W'(16'h0000), W'(16'h0000), 0, 0);
      wait_idle();
      // backpressure: result must hold and new commands must be ignored
      rdy_mode = 2;
      issue(W'(16'h1234), W'(16'h4321), 0, 0);
      n = 0;
      while (!done_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_done_seen", done_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start_valid = 1; a_in = W'($urandom); b_in = W'($urandom);
         chk("bp_start_ready", start_ready, 0);
         chk("bp_busy", busy, 1);
         chk("bp_sum", {done_valid, cout, sum_out}, {2'b10, W'(16'h5555)});
      end
      @(negedge clk);
      start_valid = 0;
      @(posedge clk);
      #1 rdy_mode = 0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_after_ready", start_ready, 1);
      chk("bp_after_busy", busy, 0);
      chk("bp_not_taken", q.size(), 0);
      // reset two cycles into RUN aborts the operation
      issue(W'(16'h0AAA), W'(16'h0555), 1, 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("mid_busy", busy, 1);
      reset = 1;
      start_valid = 1;
      @(posedge clk);
      #1 reset = 0;
      start_valid = 0;
      q.delete();
      @(negedge clk);
      chk("abort_start_ready", start_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done_valid", done_valid, 0);
      issue(W'(3), W'(6), 0, 0);
      wait_idle();
`ifdef SERIAL_ADDER_SUB_EN
      issue(W'(16'h0005), W'(16'h0007), 1, 1);
      issue(W'(16'h0009), W'(16'h0003), 0, 1);
      issue(W'(16'h8000), W'(16'h8000), 0, 1);
      wait_idle();
`endif
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
         issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
         issue(W'($urandom), W'($urandom), 1'($urandom), 0);
`endif
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      wait_idle();
      chk("final_queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
